// File: rtl/tcp_pkg.sv
// Shared constants and helpers for the TCP transmit/receive checksum datapaths.
// crc32_byte is also meant for a receive-side FCS checker.
package tcp_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // One byte of reflected CRC-32, LSB-first, unrolled into 8 bit steps.
    function automatic logic [31:0] crc32_byte(input logic [31:0] r, input logic [7:0] d);
        logic [31:0] c;
        c = r ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csum16_1b.sv
// Byte-serial 16-bit ones'-complement accumulator (Internet checksum).
// Even bytes land in the high half of a word, odd bytes in the low half.
module csum16_1b
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] acc_o,
    output logic        phase_o
);

    logic [15:0] acc_q, acc_d;
    logic        phase_q, phase_d;
    logic [15:0] addend;
    logic [16:0] sum17;

    always_comb begin
        addend  = phase_q ? {8'h00, data_i} : {data_i, 8'h00};
        sum17   = {1'b0, acc_q} + {1'b0, addend};
        acc_d   = acc_q;
        phase_d = phase_q;
        if (en_i) begin
            // End-around carry; cannot overflow again since sum17[15:0] <= FFFE when carry set.
            acc_d   = sum17[15:0] + {15'h0000, sum17[16]};
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q   <= 16'h0000;
            phase_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

    assign acc_o   = acc_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/crc_checksum_1b.sv
// TCP transmit checksum unit: Internet checksum over payload bytes and
// Ethernet FCS (CRC-32) over frame bytes, one byte per clock per engine.
module crc_checksum_1b
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        csum_en,
    input  logic [7:0]  csum_data,
    output logic [15:0] csum_out,
    output logic        csum_phase,
    input  logic        crc_init,
    input  logic        crc_en,
    input  logic [7:0]  crc_data,
    output logic [31:0] crc_out
);

    logic [15:0] acc;
    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs;

    csum16_1b u_csum (
        .clk     (clk),
        .clr     (clr),
        .en_i    (csum_en),
        .data_i  (csum_data),
        .acc_o   (acc),
        .phase_o (csum_phase)
    );

    assign csum_out = ~acc;

    // crc_init drops any byte presented in the same cycle.
    always_comb begin
        crc_d = crc_q;
        if (crc_init) begin
            crc_d = CRC32_INIT;
        end else if (crc_en) begin
            crc_d = crc32_byte(crc_q, crc_data);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // First FCS byte on the wire sits in crc_out[31:24].
    assign fcs     = ~crc_q;
    assign crc_out = {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};

endmodule

// File: tb/tb_crc_checksum_1b.sv
// Self-checking bench for crc_checksum_1b against a whole-message reference model.
module tb_crc_checksum_1b;

    logic        clk = 1'b0;
    logic        clr;
    logic        csum_en;
    logic [7:0]  csum_data;
    logic [15:0] csum_out;
    logic        csum_phase;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] cs_bytes[$];
    logic [7:0] crc_bytes[$];

    crc_checksum_1b dut (
        .clk        (clk),
        .clr        (clr),
        .csum_en    (csum_en),
        .csum_data  (csum_data),
        .csum_out   (csum_out),
        .csum_phase (csum_phase),
        .crc_init   (crc_init),
        .crc_en     (crc_en),
        .crc_data   (crc_data),
        .crc_out    (crc_out)
    );

    always #5 clk = ~clk;

    // Sum the big-endian 16-bit words of the whole message, fold at the end.
    function automatic logic [15:0] ref_csum();
        longint unsigned s = 0;
        logic [15:0] r;
        for (int i = 0; i < cs_bytes.size(); i++) begin
            if (i % 2 == 0) s += longint'(cs_bytes[i]) << 8;
            else            s += longint'(cs_bytes[i]);
        end
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        r = s[15:0];
        return ~r;
    endfunction

    function automatic logic ref_phase();
        return cs_bytes.size() % 2 == 1;
    endfunction

    // Bit-serial IEEE CRC-32 over the message, then byte-swapped for MSB-first emission.
    function automatic logic [31:0] ref_crc();
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] f;
        logic [7:0]  b;
        logic        fb;
        for (int i = 0; i < crc_bytes.size(); i++) begin
            b = crc_bytes[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        f = ~c;
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; csum_en = 1'b0; crc_en = 1'b0; crc_init = 1'b0;
        csum_data = 8'h00; crc_data = 8'h00;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        cs_bytes.delete();
        crc_bytes.delete();
    endtask

    task automatic feed_csum(input logic [7:0] b);
        csum_en = 1'b1; csum_data = b;
        step();
        csum_en = 1'b0;
        cs_bytes.push_back(b);
    endtask

    task automatic feed_crc(input logic [7:0] b);
        crc_en = 1'b1; crc_data = b;
        step();
        crc_en = 1'b0;
        crc_bytes.push_back(b);
    endtask

    task automatic test_reset();
        idle_inputs();
        do_clr();
        checks++;
        if (csum_out !== 16'hFFFF) begin
            errors++; $display("FAIL reset_csum got %h exp %h", csum_out, 16'hFFFF);
        end
        checks++;
        if (csum_phase !== 1'b0) begin
            errors++; $display("FAIL reset_phase got %b exp 0", csum_phase);
        end
        checks++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL reset_crc got %h exp %h", crc_out, 32'h0);
        end
    endtask

    task automatic test_ipv4();
        logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                                 8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
                                 8'hC0, 8'hA8, 8'h00, 8'hC7};
        do_clr();
        foreach (hdr[i]) feed_csum(hdr[i]);
        checks++;
        if (csum_out !== 16'hB861) begin
            errors++; $display("FAIL ipv4_csum got %h exp %h", csum_out, 16'hB861);
        end
        checks++;
        if (csum_out !== ref_csum()) begin
            errors++; $display("FAIL ipv4_model got %h exp %h", csum_out, ref_csum());
        end
        checks++;
        if (csum_phase !== 1'b0) begin
            errors++; $display("FAIL ipv4_phase got %b exp 0", csum_phase);
        end
    endtask

    task automatic test_odd_pad();
        do_clr();
        feed_csum(8'h01); feed_csum(8'h02); feed_csum(8'h03);
        checks++;
        if (csum_out !== 16'hFBFD || csum_phase !== 1'b1) begin
            errors++; $display("FAIL odd_stream got %h/%b exp FBFD/1", csum_out, csum_phase);
        end
        feed_csum(8'h00);
        checks++;
        if (csum_out !== 16'hFBFD || csum_phase !== 1'b0) begin
            errors++; $display("FAIL odd_pad got %h/%b exp FBFD/0", csum_out, csum_phase);
        end
    endtask

    task automatic test_carry_fold();
        do_clr();
        repeat (4) feed_csum(8'hFF);
        checks++;
        if (csum_out !== 16'h0000) begin
            errors++; $display("FAIL carry_fold got %h exp 0000", csum_out);
        end
        do_clr();
        checks++;
        if (csum_out !== 16'hFFFF || csum_phase !== 1'b0) begin
            errors++; $display("FAIL fold_clr got %h/%b exp FFFF/0", csum_out, csum_phase);
        end
    endtask

    task automatic test_crc_check();
        logic [7:0] s [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        do_clr();
        foreach (s[i]) feed_crc(s[i]);
        checks++;
        if (crc_out !== 32'h2639F4CB) begin
            errors++; $display("FAIL crc_check got %h exp %h", crc_out, 32'h2639F4CB);
        end
        crc_init = 1'b1; step(); crc_init = 1'b0;
        crc_bytes.delete();
        foreach (s[i]) begin
            feed_crc(s[i]);
            repeat ($urandom_range(0, 3)) step();
        end
        checks++;
        if (crc_out !== 32'h2639F4CB) begin
            errors++; $display("FAIL crc_gaps got %h exp %h", crc_out, 32'h2639F4CB);
        end
    endtask

    task automatic test_crc_single();
        crc_init = 1'b1; step(); crc_init = 1'b0;
        crc_bytes.delete();
        feed_crc(8'h00);
        checks++;
        if (crc_out !== 32'h8DEF02D2) begin
            errors++; $display("FAIL crc_zero_byte got %h exp %h", crc_out, 32'h8DEF02D2);
        end
        crc_init = 1'b1; crc_en = 1'b1; crc_data = 8'h5A;
        step();
        crc_init = 1'b0; crc_en = 1'b0;
        crc_bytes.delete();
        step();
        checks++;
        if (crc_out !== 32'h00000000) begin
            errors++; $display("FAIL crc_init_wins got %h exp 00000000", crc_out);
        end
    endtask

    task automatic test_latency();
        do_clr();
        csum_en = 1'b1; csum_data = 8'hAB;
        crc_en = 1'b1;  crc_data = 8'h00;
        #2;
        checks++;
        if (csum_out !== 16'hFFFF || csum_phase !== 1'b0 || crc_out !== 32'h0) begin
            errors++; $display("FAIL comb_path got %h/%b/%h exp FFFF/0/00000000", csum_out, csum_phase, crc_out);
        end
        step();
        csum_en = 1'b0; crc_en = 1'b0;
        checks++;
        if (csum_out !== 16'h54FF || csum_phase !== 1'b1 || crc_out !== 32'h8DEF02D2) begin
            errors++; $display("FAIL one_cycle got %h/%b/%h exp 54FF/1/8DEF02D2", csum_out, csum_phase, crc_out);
        end
    endtask

    task automatic test_concurrent_random();
        logic c_clr, c_init, c_cs, c_crc;
        logic [7:0] d_cs, d_crc;
        do_clr();
        for (int cyc = 0; cyc < 400; cyc++) begin
            c_clr  = (cyc == 150) || ($urandom_range(0, 59) == 0);
            c_init = ($urandom_range(0, 39) == 0);
            c_cs   = ($urandom_range(0, 3) != 0);
            c_crc  = ($urandom_range(0, 3) != 0);
            d_cs   = 8'($urandom);
            d_crc  = 8'($urandom);
            clr = c_clr; crc_init = c_init; csum_en = c_cs; crc_en = c_crc;
            csum_data = d_cs; crc_data = d_crc;
            step();
            if (c_clr) begin
                cs_bytes.delete();
                crc_bytes.delete();
            end else begin
                if (c_cs) cs_bytes.push_back(d_cs);
                if (c_init) crc_bytes.delete();
                else if (c_crc) crc_bytes.push_back(d_crc);
            end
            checks++;
            if (csum_out !== ref_csum()) begin
                errors++; $display("FAIL rnd_csum cyc %0d got %h exp %h", cyc, csum_out, ref_csum());
            end
            checks++;
            if (csum_phase !== ref_phase()) begin
                errors++; $display("FAIL rnd_phase cyc %0d got %b exp %b", cyc, csum_phase, ref_phase());
            end
            checks++;
            if (crc_out !== ref_crc()) begin
                errors++; $display("FAIL rnd_crc cyc %0d got %h exp %h", cyc, crc_out, ref_crc());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_ipv4();
        test_odd_pad();
        test_carry_fold();
        test_crc_check();
        test_crc_single();
        test_latency();
        test_concurrent_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
